pipe_processor: RTL and testbench

PIPE_PROCESSOR -- requirements
Module: pipe_processor

---
 rtl/pipe_processor.sv | 176 +++++++++++++++++
 tb/tb_pipe_processor.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_processor.sv
// -----------------------------------------------------------------------------
// pipe_processor
//
// Minimal accumulator machine. Every instruction takes two cycles: FETCH reads
// the instruction word at PC into IR and increments PC; EXEC performs the
// opcode in IR[15:12] using the operand at address IR[4:0]. HLT parks the
// machine in HALT, which only reset leaves.
//
// Memory is external. Reads are combinational: data_in is valid in the same
// cycle that address is driven. A write is committed at the next rising edge
// while readwriteN is 1.
//
// Ports
//   clk         in   single clock, all state changes on the rising edge
//   reset       in   synchronous, active-high reset
//   data_in     in   [DATA_WIDTH]  word read from memory at address
//   data_out    out  [DATA_WIDTH]  word to be written (always the accumulator)
//   readwriteN  out  1 = write data_out at address on the next edge, 0 = read
//   address     out  [ADDR_WIDTH]  memory address
// -----------------------------------------------------------------------------
module pipe_processor #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  readwriteN,
    output logic [ADDR_WIDTH-1:0] address
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_STA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h7;
    localparam logic [3:0] OP_NOT = 4'h8;
    localparam logic [3:0] OP_SHL = 4'h9;
    localparam logic [3:0] OP_SHR = 4'hA;
    localparam logic [3:0] OP_JMP = 4'hB;
    localparam logic [3:0] OP_JZ  = 4'hC;
    localparam logic [3:0] OP_JC  = 4'hD;
    localparam logic [3:0] OP_LDI = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] pc_reg,    pc_next;
    logic [DATA_WIDTH-1:0] ir_reg,    ir_next;
    logic [DATA_WIDTH-1:0] acc_reg,   acc_next;
    logic                  c_reg,     c_next;
    logic                  z_reg,     z_next;

    logic [3:0]            opcode;
    logic [ADDR_WIDTH-1:0] operand;
    logic                  acc_write;

    assign opcode   = ir_reg[DATA_WIDTH-1 -: 4];
    assign operand  = ir_reg[ADDR_WIDTH-1:0];
    assign data_out = acc_reg;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= FETCH;
            pc_reg    <= '0;
            ir_reg    <= '0;
            acc_reg   <= '0;
            c_reg     <= 1'b0;
            z_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            ir_reg    <= ir_next;
            acc_reg   <= acc_next;
            c_reg     <= c_next;
            z_reg     <= z_next;
        end
    end

    // Next-state, datapath and memory-interface outputs
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        ir_next    = ir_reg;
        acc_next   = acc_reg;
        c_next     = c_reg;
        z_next     = z_reg;
        address    = pc_reg;
        readwriteN = 1'b0;
        acc_write  = 1'b0;

        case (state_reg)
            FETCH: begin
                ir_next    = data_in;
                pc_next    = pc_reg + 1'b1;   // natural wrap 31 -> 0
                state_next = EXEC;
            end

            EXEC: begin
                address    = operand;
                state_next = FETCH;
                case (opcode)
                    OP_NOP: ;
                    OP_LDA: begin
                        acc_next  = data_in;
                        acc_write = 1'b1;
                    end
                    // Gated by reset so a write pending in the reset cycle
                    // never reaches memory.
                    OP_STA: readwriteN = ~reset;
                    OP_ADD: begin
                        {c_next, acc_next} = {1'b0, acc_reg} + {1'b0, data_in};
                        acc_write = 1'b1;
                    end
                    OP_SUB: begin
                        acc_next  = acc_reg - data_in;
                        c_next    = (acc_reg < data_in);
                        acc_write = 1'b1;
                    end
                    OP_AND: begin
                        acc_next  = acc_reg & data_in;
                        acc_write = 1'b1;
                    end
                    OP_OR: begin
                        acc_next  = acc_reg | data_in;
                        acc_write = 1'b1;
                    end
                    OP_XOR: begin
                        acc_next  = acc_reg ^ data_in;
                        acc_write = 1'b1;
                    end
                    OP_NOT: begin
                        acc_next  = ~acc_reg;
                        acc_write = 1'b1;
                    end
                    OP_SHL: begin
                        {c_next, acc_next} = {acc_reg, 1'b0};
                        acc_write = 1'b1;
                    end
                    OP_SHR: begin
                        {acc_next, c_next} = {1'b0, acc_reg};
                        acc_write = 1'b1;
                    end
                    // Jumps overwrite the increment made during FETCH.
                    OP_JMP: pc_next = operand;
                    OP_JZ:  if (z_reg) pc_next = operand;
                    OP_JC:  if (c_reg) pc_next = operand;
                    OP_LDI: begin
                        acc_next  = DATA_WIDTH'(ir_reg[11:0]);
                        acc_write = 1'b1;
                    end
                    OP_HLT: state_next = HALT;
                    default: ;
                endcase
                if (acc_write) begin
                    z_next = (acc_next == '0);
                end
            end

            HALT: ;

            default: state_next = FETCH;
        endcase
    end

endmodule

// File: tb/tb_pipe_processor.sv
// -----------------------------------------------------------------------------
// tb_pipe_processor
//
// Directed programs for pipe_processor. The bench owns a 32-word program
// memory read combinationally through address; writes issued by the DUT are
// captured in a small write log (count, last address, last data) so stores can
// be checked without the DUT ever writing the program array.
// All outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_pipe_processor;

    logic        clk;
    logic        reset;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        readwriteN;
    logic [4:0]  address;

    logic [15:0] prog [32];

    int          wr_count;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;

    int checks;
    int errors;

    pipe_processor #(
        .DATA_WIDTH(16),
        .ADDR_WIDTH(5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .data_out   (data_out),
        .readwriteN (readwriteN),
        .address    (address)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign data_in = prog[address];

    initial begin
        wr_count = 0;
        wr_addr  = '0;
        wr_data  = '0;
    end

    always @(posedge clk) begin
        if (readwriteN === 1'b1) begin
            wr_count <= wr_count + 1;
            wr_addr  <= address;
            wr_data  <= data_out;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle, ending on the falling edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 32; i++) prog[i] = 16'h0000;
    endtask

    // Reset held for two edges, released on a falling edge.
    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    logic [15:0] exp_acc [14];
    int          wr_before;

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        clear_prog();
        @(negedge clk);

        // ---------------- reset state ----------------
        step(2);
        check("rst_address", 32'(address), 32'h0);
        check("rst_data_out", 32'(data_out), 32'h0);
        check("rst_rw", 32'(readwriteN), 32'h0);

        // ---------------- LDI / ADD / STA / HLT ----------------
        clear_prog();
        prog[0]  = 16'hE005;
        prog[1]  = 16'h3010;
        prog[2]  = 16'h2011;
        prog[3]  = 16'hF000;
        prog[16] = 16'h0003;
        do_reset();
        wr_before = wr_count;
        check("p1_fetch0_addr", 32'(address), 32'h0);
        step(1);
        check("p1_exec_ldi_addr", 32'(address), 32'h05);
        step(1);
        check("p1_acc_ldi", 32'(data_out), 32'h0005);
        step(2);
        check("p1_acc_add", 32'(data_out), 32'h0008);
        step(1);
        check("p1_sta_rw", 32'(readwriteN), 32'h1);
        check("p1_sta_addr", 32'(address), 32'h11);
        step(3);
        check("p1_wr_count", 32'(wr_count - wr_before), 32'h1);
        check("p1_wr_addr", 32'(wr_addr), 32'h11);
        check("p1_wr_data", 32'(wr_data), 32'h0008);
        check("p1_halt_acc", 32'(data_out), 32'h0008);
        check("p1_halt_rw", 32'(readwriteN), 32'h0);
        check("p1_halt_pc", 32'(address), 32'h04);
        step(5);
        check("p1_halt_stay_pc", 32'(address), 32'h04);
        check("p1_halt_stay_acc", 32'(data_out), 32'h0008);

        // ---------------- ADD carry-out, C and Z via JC/JZ ----------------
        clear_prog();
        prog[0]  = 16'h1010;   // LDA 16
        prog[1]  = 16'h3011;   // ADD 17
        prog[2]  = 16'hD00A;   // JC 10
        prog[3]  = 16'hF000;
        prog[10] = 16'hC00C;   // JZ 12
        prog[11] = 16'hF000;
        prog[12] = 16'hF000;
        prog[16] = 16'hFFFF;
        prog[17] = 16'h0001;
        do_reset();
        step(2);
        check("p2_acc_lda", 32'(data_out), 32'hFFFF);
        step(2);
        check("p2_acc_add", 32'(data_out), 32'h0000);
        step(2);
        check("p2_jc_target", 32'(address), 32'h0A);
        step(6);
        check("p2_halt_pc", 32'(address), 32'h0D);

        // ---------------- LDI 0 / JZ 7 ----------------
        clear_prog();
        prog[0] = 16'hE000;
        prog[1] = 16'hC007;
        prog[7] = 16'hF000;
        do_reset();
        step(4);
        check("p3_fetch_after_jz", 32'(address), 32'h07);
        step(2);
        check("p3_halt_pc", 32'(address), 32'h08);
        check("p3_acc", 32'(data_out), 32'h0000);

        // ---------------- JMP 31 and PC wrap ----------------
        clear_prog();
        prog[0]  = 16'hB01F;
        prog[31] = 16'h0000;
        do_reset();
        step(2);
        check("p4_fetch31", 32'(address), 32'h1F);
        step(2);
        check("p4_wrap_fetch0", 32'(address), 32'h00);

        // ---------------- remaining ALU ops, ignored IR bits ----------------
        clear_prog();
        prog[0]  = 16'hE0F3;   // LDI 0x0F3
        prog[1]  = 16'h5FF4;   // AND 20 (IR[11:5] set, ignored)
        prog[2]  = 16'h6015;   // OR 21
        prog[3]  = 16'h7014;   // XOR 20
        prog[4]  = 16'h8000;   // NOT
        prog[5]  = 16'h9000;   // SHL (C=1)
        prog[6]  = 16'hD009;   // JC 9 taken
        prog[7]  = 16'hF000;
        prog[8]  = 16'hF000;
        prog[9]  = 16'hA000;   // SHR (C=0)
        prog[10] = 16'h4017;   // SUB 23, no borrow
        prog[11] = 16'hD00F;   // JC 15 not taken
        prog[12] = 16'hE003;   // LDI 3
        prog[13] = 16'h4017;   // SUB 23, borrow
        prog[14] = 16'hD012;   // JC 18 taken
        prog[15] = 16'hF000;
        prog[16] = 16'hF000;
        prog[17] = 16'hF000;
        prog[18] = 16'h0000;   // NOP
        prog[19] = 16'hF000;
        prog[20] = 16'h00F0;
        prog[21] = 16'h0F0F;
        prog[23] = 16'h0005;
        exp_acc = '{16'h00F3, 16'h00F0, 16'h0FFF, 16'h0F0F, 16'hF0F0, 16'hE1E0, 16'hE1E0,
                    16'h70F0, 16'h70EB, 16'h70EB, 16'h0003, 16'hFFFE, 16'hFFFE, 16'hFFFE};
        do_reset();
        for (int i = 0; i < 14; i++) begin
            step(2);
            check($sformatf("p5_acc_%0d", i), 32'(data_out), 32'(exp_acc[i]));
        end
        step(2);
        check("p5_halt_pc", 32'(address), 32'h14);

        // ---------------- reset during EXEC of STA ----------------
        clear_prog();
        prog[0] = 16'hE009;    // LDI 9
        prog[1] = 16'h2014;    // STA 20
        prog[2] = 16'hF000;
        do_reset();
        step(3);
        check("p6_sta_rw", 32'(readwriteN), 32'h1);
        check("p6_sta_addr", 32'(address), 32'h14);
        reset = 1'b1;
        #1;
        check("p6_rw_in_reset", 32'(readwriteN), 32'h0);
        wr_before = wr_count;
        step(1);
        check("p6_no_write", 32'(wr_count - wr_before), 32'h0);
        check("p6_addr_after", 32'(address), 32'h00);
        check("p6_acc_after", 32'(data_out), 32'h0000);
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
